// File: rtl/ocs_slot_scheduler.sv
// Slot scheduler for the 8x8 OCS: round-robin output arbitration, permutation fill, controller handshake, guard time, data slot.
// Optional build macro OCS_SKIP_RECONF_EN: reuse the last granted configuration without a controller round trip.
module ocs_slot_scheduler #(
  parameter int P_PORTNUM       = 8,
  parameter int P_DSTWIDTH      = 3,
  parameter int P_GRANTWIDTH    = 20,
  parameter int P_RECONF_CYCLES = 16,
  parameter int P_SLOT_CYCLES   = 64,
  parameter int P_TIMEOUT       = 255
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [P_PORTNUM-1:0]             i_port_req,
  input  logic [P_PORTNUM*P_DSTWIDTH-1:0]  i_port_dst,
  output logic [P_PORTNUM-1:0]             o_port_grant,
  output logic [P_PORTNUM-1:0]             o_port_conn,
  output logic                             o_slot_active,
  output logic [P_PORTNUM*P_DSTWIDTH-1:0]  o_8x8_req,
  output logic                             o_8x8_valid,
  input  logic [P_GRANTWIDTH-1:0]          i_grant_8x8,
  input  logic                             i_grant_valid,
  output logic [P_GRANTWIDTH-1:0]          o_grant_8x8,
  output logic                             o_grant_load,
  output logic                             o_err_timeout
);

  localparam int TW = 16;
  localparam int PW = P_PORTNUM * P_DSTWIDTH;
  localparam logic [TW-1:0] LP_TO_LAST     = TW'(P_TIMEOUT - 1);
  localparam logic [TW-1:0] LP_RECONF_LAST = TW'(P_RECONF_CYCLES - 1);
  localparam logic [TW-1:0] LP_SLOT_LAST   = TW'(P_SLOT_CYCLES - 1);
  localparam logic [P_DSTWIDTH-1:0] LP_FILL_LAST = P_DSTWIDTH'(P_PORTNUM - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARB    = 3'd1,
    S_FILL   = 3'd2,
    S_ISSUE  = 3'd3,
    S_WAIT   = 3'd4,
    S_RECONF = 3'd5,
    S_ACTIVE = 3'd6
  } state_t;

  state_t                    state_q, state_d;
  logic [P_DSTWIDTH-1:0]     rr_q, rr_d, fill_idx_q, fill_idx_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic [P_PORTNUM-1:0]      matched_q, matched_d, used_q, used_d;
  logic [PW-1:0]             perm_q, perm_d, req_q, req_d;
  logic                      valid_q, valid_d, load_q, load_d, active_q, active_d, err_q, err_d;
  logic [P_GRANTWIDTH-1:0]   grant_q, grant_d;
  logic [P_PORTNUM-1:0]      pgrant_q, pgrant_d, conn_q, conn_d;
  logic [P_PORTNUM-1:0]      arb_match_s, arb_used_s, fill_used_s;
  logic [PW-1:0]             fill_perm_s;
  logic [P_DSTWIDTH-1:0]     low_s;
`ifdef OCS_SKIP_RECONF_EN
  logic [PW-1:0]             last_perm_q, last_perm_d;
  logic                      last_vld_q, last_vld_d;
`endif

  // Output d goes to the first requester for d at or after the rr pointer; a port wins unless a closer rival shares its dst.
  always_comb begin
    arb_match_s = '0;
    arb_used_s  = '0;
    for (int p = 0; p < P_PORTNUM; p++) begin
      logic [P_DSTWIDTH-1:0] dst_p, dist_p, dst_o, dist_o;
      logic                  win_s;
      dst_p  = i_port_dst[p*P_DSTWIDTH +: P_DSTWIDTH];
      dist_p = P_DSTWIDTH'(p) - rr_q;
      win_s  = i_port_req[p];
      for (int q = 0; q < P_PORTNUM; q++) begin
        dst_o  = i_port_dst[q*P_DSTWIDTH +: P_DSTWIDTH];
        dist_o = P_DSTWIDTH'(q) - rr_q;
        win_s  = win_s & ~(i_port_req[q] & (dst_o == dst_p) & (dist_o < dist_p));
      end
      arb_match_s[p]       = win_s;
      arb_used_s[dst_p]    = arb_used_s[dst_p] | win_s;
    end
  end

  // One fill step: an unmatched input takes the lowest output nobody holds yet.
  always_comb begin
    low_s = '0;
    for (int o = P_PORTNUM - 1; o >= 0; o--) begin
      low_s = used_q[o] ? low_s : P_DSTWIDTH'(o);
    end
    fill_perm_s = perm_q;
    fill_used_s = used_q;
    fill_perm_s[fill_idx_q*P_DSTWIDTH +: P_DSTWIDTH] =
      matched_q[fill_idx_q] ? perm_q[fill_idx_q*P_DSTWIDTH +: P_DSTWIDTH] : low_s;
    fill_used_s[low_s] = used_q[low_s] | ~matched_q[fill_idx_q];
  end

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    fill_idx_d = fill_idx_q;
    timer_d    = timer_q;
    matched_d  = matched_q;
    used_d     = used_q;
    perm_d     = perm_q;
    req_d      = req_q;
    valid_d    = 1'b0;
    load_d     = 1'b0;
    grant_d    = grant_q;
    pgrant_d   = '0;
    conn_d     = conn_q;
    active_d   = active_q;
    err_d      = err_q;
`ifdef OCS_SKIP_RECONF_EN
    last_perm_d = last_perm_q;
    last_vld_d  = last_vld_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|i_port_req) begin
          state_d = S_ARB;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ARB: begin
        matched_d  = arb_match_s;
        used_d     = arb_used_s;
        perm_d     = i_port_dst;
        fill_idx_d = '0;
        state_d    = S_FILL;
      end
      S_FILL: begin
        perm_d     = fill_perm_s;
        used_d     = fill_used_s;
        fill_idx_d = fill_idx_q + 1'b1;
        if (fill_idx_q == LP_FILL_LAST) begin
`ifdef OCS_SKIP_RECONF_EN
          if (last_vld_q && (fill_perm_s == last_perm_q)) begin
            state_d  = S_ACTIVE;
            timer_d  = '0;
            pgrant_d = matched_q;
            conn_d   = matched_q;
            active_d = 1'b1;
          end else begin
            state_d = S_ISSUE;
            req_d   = fill_perm_s;
            valid_d = 1'b1;
          end
`else
          state_d = S_ISSUE;
          req_d   = fill_perm_s;
          valid_d = 1'b1;
`endif
        end else begin
          state_d = S_FILL;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        timer_d = '0;
      end
      S_WAIT: begin
        if (i_grant_valid) begin
          grant_d = i_grant_8x8;
          load_d  = 1'b1;
          timer_d = '0;
          state_d = S_RECONF;
`ifdef OCS_SKIP_RECONF_EN
          last_perm_d = req_q;
          last_vld_d  = 1'b1;
`endif
        end else if (timer_q == LP_TO_LAST) begin
          err_d   = 1'b1;
          timer_d = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_RECONF: begin
        if (timer_q == LP_RECONF_LAST) begin
          state_d  = S_ACTIVE;
          timer_d  = '0;
          pgrant_d = matched_q;
          conn_d   = matched_q;
          active_d = 1'b1;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_ACTIVE: begin
        if (timer_q == LP_SLOT_LAST) begin
          state_d  = S_IDLE;
          timer_d  = '0;
          rr_d     = rr_q + 1'b1;
          conn_d   = '0;
          active_d = 1'b0;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      rr_q       <= '0;
      fill_idx_q <= '0;
      timer_q    <= '0;
      matched_q  <= '0;
      used_q     <= '0;
      perm_q     <= '0;
      req_q      <= '0;
      valid_q    <= 1'b0;
      load_q     <= 1'b0;
      grant_q    <= '0;
      pgrant_q   <= '0;
      conn_q     <= '0;
      active_q   <= 1'b0;
      err_q      <= 1'b0;
`ifdef OCS_SKIP_RECONF_EN
      last_perm_q <= '0;
      last_vld_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      fill_idx_q <= fill_idx_d;
      timer_q    <= timer_d;
      matched_q  <= matched_d;
      used_q     <= used_d;
      perm_q     <= perm_d;
      req_q      <= req_d;
      valid_q    <= valid_d;
      load_q     <= load_d;
      grant_q    <= grant_d;
      pgrant_q   <= pgrant_d;
      conn_q     <= conn_d;
      active_q   <= active_d;
      err_q      <= err_d;
`ifdef OCS_SKIP_RECONF_EN
      last_perm_q <= last_perm_d;
      last_vld_q  <= last_vld_d;
`endif
    end
  end

  assign o_port_grant  = pgrant_q;
  assign o_port_conn   = conn_q;
  assign o_slot_active = active_q;
  assign o_8x8_req     = req_q;
  assign o_8x8_valid   = valid_q;
  assign o_grant_8x8   = grant_q;
  assign o_grant_load  = load_q;
  assign o_err_timeout = err_q;

endmodule

// File: tb/tb_ocs_slot_scheduler.sv
// Directed self-checking bench for ocs_slot_scheduler; drives and samples on the falling clock edge.
module tb_ocs_slot_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  port_req = 8'h00;
  logic [23:0] port_dst = 24'h000000;
  logic [7:0]  port_grant, port_conn;
  logic        slot_active, req_valid, grant_load, err_timeout;
  logic [23:0] req_perm;
  logic [19:0] grant_in = 20'h00000;
  logic        grant_valid = 1'b0;
  logic [19:0] grant_out;

  int n_checks = 0;
  int n_fail = 0;
  int cnt_valid = 0;
  int cnt_load = 0;
  int cnt_pgrant = 0;

  localparam logic [23:0] ID_PERM = 24'hFAC688;
  localparam logic [23:0] DST_0_3_TO_5 = 24'h000A05;

  ocs_slot_scheduler dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_port_req    (port_req),
    .i_port_dst    (port_dst),
    .o_port_grant  (port_grant),
    .o_port_conn   (port_conn),
    .o_slot_active (slot_active),
    .o_8x8_req     (req_perm),
    .o_8x8_valid   (req_valid),
    .i_grant_8x8   (grant_in),
    .i_grant_valid (grant_valid),
    .o_grant_8x8   (grant_out),
    .o_grant_load  (grant_load),
    .o_err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (req_valid)  cnt_valid  <= cnt_valid + 1;
    if (grant_load) cnt_load   <= cnt_load + 1;
    if (|port_grant) cnt_pgrant <= cnt_pgrant + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Full slot: request, expect issue 10 cycles later, grant after 3 cycles, 16-cycle guard, 64-cycle slot.
  task automatic do_slot(input string tag, input logic [7:0] req, input logic [23:0] dst,
                         input logic [23:0] exp_perm, input logic [7:0] exp_win, input bit drop);
    int cyc;
    int l0;
    port_req = req;
    port_dst = dst;
    cyc = 0;
    while (!req_valid && cyc < 40) begin @(negedge clk); cyc++; end
    check_val({tag, "_issue_lat"}, cyc, 10);
    check_val({tag, "_perm"}, req_perm, exp_perm);
    repeat (3) @(negedge clk);
    grant_in = 20'h5A5A5;
    grant_valid = 1'b1;
    @(negedge clk);
    grant_valid = 1'b0;
    check_val({tag, "_load"}, grant_load, 1);
    check_val({tag, "_grant_out"}, grant_out, 20'h5A5A5);
    @(negedge clk);
    check_val({tag, "_load_pulse"}, grant_load, 0);
    cyc = 1;
    while (port_grant == 8'h00 && cyc < 40) begin @(negedge clk); cyc++; end
    check_val({tag, "_reconf_len"}, cyc, 16);
    check_val({tag, "_port_grant"}, port_grant, exp_win);
    check_val({tag, "_port_conn"}, port_conn, exp_win);
    if (drop) port_req = 8'h00;
    l0 = cnt_load;
    cyc = 0;
    while (slot_active && cyc < 100) begin
      grant_valid = (cyc == 5);
      grant_in = 20'hFFFFF;
      cyc++;
      @(negedge clk);
    end
    grant_valid = 1'b0;
    check_val({tag, "_slot_len"}, cyc, 64);
    check_val({tag, "_conn_clear"}, port_conn, 0);
    check_val({tag, "_stray_grant"}, grant_out, 20'h5A5A5);
    check_val({tag, "_stray_load"}, cnt_load - l0, 0);
    check_val({tag, "_req_hold"}, req_perm, exp_perm);
  endtask

  initial begin
    int cyc;
    int v0, l0, g0;
    repeat (2) @(negedge clk);
    check_val("rst_outs", {slot_active, req_valid, grant_load, err_timeout, port_grant, port_conn}, 0);
    check_val("rst_grant", grant_out, 0);
    check_val("rst_req", req_perm, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_slot("rr0", 8'h09, DST_0_3_TO_5, 24'hFA3445, 8'h01, 1'b0);
    do_slot("rr1", 8'h09, DST_0_3_TO_5, 24'hFA3A88, 8'h08, 1'b1);
    @(negedge clk);
    do_slot("ident", 8'hFF, ID_PERM, ID_PERM, 8'hFF, 1'b1);
    @(negedge clk);

`ifdef OCS_SKIP_RECONF_EN
    v0 = cnt_valid;
    l0 = cnt_load;
    port_req = 8'hFF;
    port_dst = ID_PERM;
    cyc = 0;
    while (port_grant == 8'h00 && cyc < 40) begin @(negedge clk); cyc++; end
    check_val("skip_lat", cyc, 10);
    check_val("skip_port_grant", port_grant, 8'hFF);
    port_req = 8'h00;
    cyc = 0;
    while (slot_active && cyc < 100) begin cyc++; @(negedge clk); end
    check_val("skip_slot_len", cyc, 64);
    check_val("skip_no_valid", cnt_valid - v0, 0);
    check_val("skip_no_load", cnt_load - l0, 0);
    check_val("skip_grant_kept", grant_out, 20'h5A5A5);
`else
    do_slot("repeat", 8'hFF, ID_PERM, ID_PERM, 8'hFF, 1'b1);
`endif
    @(negedge clk);

    port_req = 8'h01;
    port_dst = 24'h000000;
    cyc = 0;
    while (!req_valid && cyc < 40) begin @(negedge clk); cyc++; end
    check_val("to_issue_lat", cyc, 10);
    port_req = 8'h00;
    l0 = cnt_load;
    g0 = cnt_pgrant;
    repeat (255) @(negedge clk);
    check_val("to_err_before", err_timeout, 0);
    @(negedge clk);
    check_val("to_err_set", err_timeout, 1);
    v0 = cnt_valid;
    repeat (20) @(negedge clk);
    check_val("to_no_load", cnt_load - l0, 0);
    check_val("to_no_pgrant", cnt_pgrant - g0, 0);
    check_val("to_idle", cnt_valid - v0, 0);
    check_val("to_sticky", err_timeout, 1);

    port_req = 8'hFF;
    port_dst = ID_PERM;
    cyc = 0;
    while (!req_valid && cyc < 40) begin @(negedge clk); cyc++; end
    check_val("mid_issue_lat", cyc, 10);
    repeat (3) @(negedge clk);
    grant_in = 20'h12345;
    grant_valid = 1'b1;
    @(negedge clk);
    grant_valid = 1'b0;
    cyc = 0;
    while (!slot_active && cyc < 40) begin @(negedge clk); cyc++; end
    repeat (10) @(negedge clk);
    check_val("mid_active_pre", slot_active, 1);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_active", slot_active, 0);
    check_val("mid_rst_conn", port_conn, 0);
    check_val("mid_rst_grant", grant_out, 0);
    check_val("mid_rst_err", err_timeout, 0);
    port_req = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_slot("post_rst_rr0", 8'h09, DST_0_3_TO_5, 24'hFA3445, 8'h01, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
